lsb_addr_sched: RTL
===================

# lsb_addr_sched

Two-source scheduler that shares the single load/store address ALU between the load buffer and the store buffer. It queues address-computation requests from each source in a small per-source FIFO and grants at most one request per cycle with round-robin arbitration. It drives the ALU's `new`/operand inputs from registers. It sits between the LSB issue logic and the address ALU, and honours the global `rdy_in` stall and pipeline flush.

## Interface
- `ROB_SIZE_BIT`, 4, width of ROB entry tags
- `DEPTH`, 4, entries per source FIFO; must be a power of two, ≥2
- `PTR_W`, 2, log2(`DEPTH`)

- `clk_in`  in  1  system clock; all state updates on rising edge
- `rst_in`  in  1  reset; one clock, synchronous, active-low
- `rdy_in`  in  1  global ready; when low, no state changes
- `flush_in`  in  1  mispredict flush; discards all queued and in-flight requests
- `ld_valid`  in  1  load request valid
- `ld_ready`  out  1  load FIFO can accept
- `ld_vi`  in  32  load base value
- `ld_imm`  in  12  load offset
- `ld_rob`  in  `ROB_SIZE_BIT`  load ROB tag
- `st_valid`, `st_ready`, `st_vi`, `st_imm`, `st_rob`  same directions and widths, store/jalr source
- `alu_new`  out  1  issue strobe to the address ALU
- `alu_vi`  out  32  issued base value
- `alu_imm`  out  12  issued offset
- `alu_op`  out  1  0 = load, 1 = store/jalr
- `alu_rob_entry`  out  `ROB_SIZE_BIT`  issued ROB tag
- `ld_count`, `st_count`  out  `PTR_W`+1  current FIFO occupancy

## Operation
- **Per-source FIFOs.** Each FIFO has `DEPTH` entries of {vi, imm, rob}, a read pointer, a write pointer and a count. Pointers wrap modulo `DEPTH`.
- **Ready.** `ld_ready` = (`ld_count` < `DEPTH`); `st_ready` likewise. Both are combinational from the registered count only and never depend on a same-cycle pop.
- **Push.** A push occurs when `x_valid` && `x_ready` && `rdy_in` && `rst_in` && !`flush_in`.
- **Eligibility.** A source is eligible when its registered count is nonzero. An entry pushed at edge k can be granted no earlier than edge k+1.
- **Arbitration.** Performed only when `rdy_in` is high and `flush_in` is low.
  - Only one source eligible: grant it.
  - Both eligible: grant the source selected by the `prio` bit.
  - After any grant, `prio` points to the other source.
  - `prio` resets to load.
- **Grant.** The head entry of the granted FIFO is popped and its contents are registered into `alu_vi`/`alu_imm`/`alu_rob_entry`. `alu_op` takes the source id and `alu_new` is set to 1.
- **No grant** (nothing eligible, `rdy_in` high): `alu_new` is 0 and the other `alu_*` outputs hold their values.
- **Push and pop on one FIFO in the same cycle:** the count is unchanged and both pointers advance.
- **`rdy_in` low:** all registers hold, including `alu_new`. The ALU ignores `alu_new` while stalled, so it is not issued twice.
- **`flush_in` high with `rdy_in` high:**
  - Both counts and all four pointers are set to 0.
  - `alu_new` is set to 0.
  - `prio` is set to load.
  - Same-cycle pushes and grants are discarded.
- **`flush_in` high with `rdy_in` low:** ignored.
- **Reset** (`rst_in` low at an edge) overrides `rdy_in` and `flush_in`:
  - `alu_new`, `alu_vi`, `alu_imm`, `alu_op`, `alu_rob_entry` all reset to 0.
  - `ld_count` and `st_count` reset to 0; all pointers reset to 0; `prio` resets to load.
  - `ld_ready` and `st_ready` read 1 immediately after reset.
  - Reset asserted mid-operation drops all queued entries.
- FIFO storage arrays are not reset.

## Timing
- Latency from push to `alu_new`: 1 cycle minimum. A request accepted at edge k appears with `alu_new` = 1 after edge k+1, when the FIFO is empty and the source wins arbitration.
- Throughput: one grant per unstalled cycle.
- Fairness: with both sources continuously eligible, grants alternate strictly L, S, L, S… starting from the current `prio`. Worst-case wait is `DEPTH`·2 grants.
- A full FIFO that pops at edge k shows `x_ready` = 1 only after edge k.
- `alu_new` is a one-cycle strobe per grant and is never high on two consecutive unstalled cycles for the same entry.

## Test plan
- **Reset.** Hold `rst_in` = 0 for 2 cycles with random inputs, then release → `alu_new` = 0, counts = 0, `ld_ready` = `st_ready` = 1, first unstalled cycle with no valid gives `alu_new` = 0.
- **Single load.** Push ld {vi = 0x1000, imm = 0xFFC, rob = 3} at edge 0 → after edge 1: `alu_new` = 1, `alu_vi` = 0x1000, `alu_imm` = 0xFFC, `alu_op` = 0, `alu_rob_entry` = 3. After edge 2: `alu_new` = 0.
- **Round-robin.** Fill both FIFOs with 4 entries each (ld rob 0–3, st rob 8–11), then stop pushing → eight consecutive grants with rob order 0, 8, 1, 9, 2, 10, 3, 11 and `alu_op` alternating 0/1. Counts reach 0 and then `alu_new` = 0.
- **Full / backpressure.** Push 4 loads without grants possible → `ld_ready` = 0 and a 5th `ld_valid` is not accepted. One pop → `ld_ready` = 1 the following cycle. With simultaneous push and pop on a non-full FIFO, the count is unchanged.
- **Stall.** Drop `rdy_in` for 3 cycles while both FIFOs hold entries → counts, pointers and `alu_*` are frozen and no pushes are accepted. Resume → issue continues in the same order with no duplicate and no lost rob tag.
- **Flush.** Assert `flush_in` while 3 loads and 2 stores are queued and `ld_valid` is high → next cycle: counts = 0, `alu_new` = 0, the pushed load is discarded and `prio` = load.

Source files
------------

// File: rtl/lsb_addr_sched.sv
// lsb_addr_sched
//   Shares the single load/store address ALU between the load buffer and the
//   store buffer. Each source owns a DEPTH-entry FIFO of {vi, imm, rob}
//   requests; at most one head entry is granted per unstalled cycle using a
//   one-bit round-robin priority, and the granted request is registered onto
//   the alu_* outputs together with a one-cycle alu_new strobe.
//
// Ports
//   clk_in, rst_in      clock; synchronous active-low reset
//   rdy_in              global ready; low freezes every register
//   flush_in            discards queued and in-flight requests (when rdy_in)
//   ld_valid/ld_ready   load request handshake, payload ld_vi/ld_imm/ld_rob
//   st_valid/st_ready   store/jalr request handshake, payload st_vi/st_imm/st_rob
//   alu_new             issue strobe to the address ALU
//   alu_vi/alu_imm      issued base value and offset
//   alu_op              issued source id (0 = load, 1 = store/jalr)
//   alu_rob_entry       issued ROB tag
//   ld_count/st_count   current FIFO occupancy
module lsb_addr_sched #(
  parameter int ROB_SIZE_BIT = 4,
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [31:0]             ld_vi,
  input  logic [11:0]             ld_imm,
  input  logic [ROB_SIZE_BIT-1:0] ld_rob,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [31:0]             st_vi,
  input  logic [11:0]             st_imm,
  input  logic [ROB_SIZE_BIT-1:0] st_rob,
  output logic                    alu_new,
  output logic [31:0]             alu_vi,
  output logic [11:0]             alu_imm,
  output logic                    alu_op,
  output logic [ROB_SIZE_BIT-1:0] alu_rob_entry,
  output logic [PTR_W:0]          ld_count,
  output logic [PTR_W:0]          st_count
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    SRC_LD = 1'b0,
    SRC_ST = 1'b1
  } src_e;

  typedef struct packed {
    logic [31:0]             vi;
    logic [11:0]             imm;
    logic [ROB_SIZE_BIT-1:0] rob;
  } entry_t;

  // Request storage; contents are qualified by the counts, so never reset.
  entry_t ld_mem_q [DEPTH];
  entry_t st_mem_q [DEPTH];

  logic [PTR_W-1:0]        ld_rd_ptr_q, ld_rd_ptr_d, ld_wr_ptr_q, ld_wr_ptr_d;
  logic [PTR_W-1:0]        st_rd_ptr_q, st_rd_ptr_d, st_wr_ptr_q, st_wr_ptr_d;
  logic [CNT_W-1:0]        ld_count_q, ld_count_d, st_count_q, st_count_d;
  src_e                    prio_q, prio_d;
  logic                    alu_new_q, alu_new_d;
  logic [31:0]             alu_vi_q, alu_vi_d;
  logic [11:0]             alu_imm_q, alu_imm_d;
  src_e                    alu_op_q, alu_op_d;
  logic [ROB_SIZE_BIT-1:0] alu_rob_q, alu_rob_d;

  logic   ld_push_s, st_push_s;
  logic   ld_pop_s, st_pop_s;
  logic   ld_elig_s, st_elig_s;
  logic   active_s;
  entry_t ld_head_s, st_head_s;
  entry_t ld_in_s, st_in_s;

  // Ready depends on the registered count only, never on a same-cycle pop.
  assign ld_ready  = (ld_count_q < DEPTH_C);
  assign st_ready  = (st_count_q < DEPTH_C);
  assign ld_elig_s = (ld_count_q != {CNT_W{1'b0}});
  assign st_elig_s = (st_count_q != {CNT_W{1'b0}});
  assign active_s  = rdy_in && rst_in && !flush_in;
  assign ld_push_s = ld_valid && ld_ready && active_s;
  assign st_push_s = st_valid && st_ready && active_s;
  assign ld_head_s = ld_mem_q[ld_rd_ptr_q];
  assign st_head_s = st_mem_q[st_rd_ptr_q];
  assign ld_in_s   = '{vi: ld_vi, imm: ld_imm, rob: ld_rob};
  assign st_in_s   = '{vi: st_vi, imm: st_imm, rob: st_rob};

  // Round-robin arbitration between the two eligible FIFO heads.
  always_comb begin
    ld_pop_s = 1'b0;
    st_pop_s = 1'b0;
    if (active_s) begin
      if (ld_elig_s && (!st_elig_s || (prio_q == SRC_LD))) begin
        ld_pop_s = 1'b1;
      end else if (st_elig_s) begin
        st_pop_s = 1'b1;
      end else begin
        ld_pop_s = 1'b0;
        st_pop_s = 1'b0;
      end
    end else begin
      ld_pop_s = 1'b0;
      st_pop_s = 1'b0;
    end
  end

  // Next-state for pointers, counts, priority and the registered ALU issue.
  always_comb begin
    ld_rd_ptr_d = ld_rd_ptr_q;
    ld_wr_ptr_d = ld_wr_ptr_q;
    st_rd_ptr_d = st_rd_ptr_q;
    st_wr_ptr_d = st_wr_ptr_q;
    ld_count_d  = ld_count_q;
    st_count_d  = st_count_q;
    prio_d      = prio_q;
    alu_new_d   = alu_new_q;
    alu_vi_d    = alu_vi_q;
    alu_imm_d   = alu_imm_q;
    alu_op_d    = alu_op_q;
    alu_rob_d   = alu_rob_q;

    if (rdy_in && flush_in) begin
      ld_rd_ptr_d = {PTR_W{1'b0}};
      ld_wr_ptr_d = {PTR_W{1'b0}};
      st_rd_ptr_d = {PTR_W{1'b0}};
      st_wr_ptr_d = {PTR_W{1'b0}};
      ld_count_d  = {CNT_W{1'b0}};
      st_count_d  = {CNT_W{1'b0}};
      prio_d      = SRC_LD;
      alu_new_d   = 1'b0;
    end else if (rdy_in) begin
      // Pointers wrap naturally because DEPTH is a power of two.
      ld_wr_ptr_d = ld_push_s ? (ld_wr_ptr_q + PTR_W'(1)) : ld_wr_ptr_q;
      st_wr_ptr_d = st_push_s ? (st_wr_ptr_q + PTR_W'(1)) : st_wr_ptr_q;
      ld_rd_ptr_d = ld_pop_s  ? (ld_rd_ptr_q + PTR_W'(1)) : ld_rd_ptr_q;
      st_rd_ptr_d = st_pop_s  ? (st_rd_ptr_q + PTR_W'(1)) : st_rd_ptr_q;
      // Simultaneous push and pop leaves the count unchanged.
      ld_count_d  = ld_count_q + CNT_W'(ld_push_s) - CNT_W'(ld_pop_s);
      st_count_d  = st_count_q + CNT_W'(st_push_s) - CNT_W'(st_pop_s);

      if (ld_pop_s) begin
        alu_new_d = 1'b1;
        alu_vi_d  = ld_head_s.vi;
        alu_imm_d = ld_head_s.imm;
        alu_rob_d = ld_head_s.rob;
        alu_op_d  = SRC_LD;
        prio_d    = SRC_ST;
      end else if (st_pop_s) begin
        alu_new_d = 1'b1;
        alu_vi_d  = st_head_s.vi;
        alu_imm_d = st_head_s.imm;
        alu_rob_d = st_head_s.rob;
        alu_op_d  = SRC_ST;
        prio_d    = SRC_LD;
      end else begin
        // No grant: drop the strobe, keep the last issued operands.
        alu_new_d = 1'b0;
      end
    end else begin
      // Stalled: every register holds, including alu_new.
      alu_new_d = alu_new_q;
    end
  end

  // Control and issue registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ld_rd_ptr_q <= {PTR_W{1'b0}};
      ld_wr_ptr_q <= {PTR_W{1'b0}};
      st_rd_ptr_q <= {PTR_W{1'b0}};
      st_wr_ptr_q <= {PTR_W{1'b0}};
      ld_count_q  <= {CNT_W{1'b0}};
      st_count_q  <= {CNT_W{1'b0}};
      prio_q      <= SRC_LD;
      alu_new_q   <= 1'b0;
      alu_vi_q    <= 32'd0;
      alu_imm_q   <= 12'd0;
      alu_op_q    <= SRC_LD;
      alu_rob_q   <= {ROB_SIZE_BIT{1'b0}};
    end else begin
      ld_rd_ptr_q <= ld_rd_ptr_d;
      ld_wr_ptr_q <= ld_wr_ptr_d;
      st_rd_ptr_q <= st_rd_ptr_d;
      st_wr_ptr_q <= st_wr_ptr_d;
      ld_count_q  <= ld_count_d;
      st_count_q  <= st_count_d;
      prio_q      <= prio_d;
      alu_new_q   <= alu_new_d;
      alu_vi_q    <= alu_vi_d;
      alu_imm_q   <= alu_imm_d;
      alu_op_q    <= alu_op_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  // FIFO storage writes; the push qualifiers already include reset and flush.
  always_ff @(posedge clk_in) begin
    if (ld_push_s) begin
      ld_mem_q[ld_wr_ptr_q] <= ld_in_s;
    end
    if (st_push_s) begin
      st_mem_q[st_wr_ptr_q] <= st_in_s;
    end
  end

  assign alu_new       = alu_new_q;
  assign alu_vi        = alu_vi_q;
  assign alu_imm       = alu_imm_q;
  assign alu_op        = alu_op_q;
  assign alu_rob_entry = alu_rob_q;
  assign ld_count      = ld_count_q;
  assign st_count      = st_count_q;

endmodule
